// File: rtl/serial_vector_sum_pkg.sv
// Sequencer state encodings and single-precision helpers shared by serial_vector_sum
// and any later time-shared sequencers; guarded so it can be pulled in more than once.
`ifndef SERIAL_VECTOR_SUM_PKG_SV
`define SERIAL_VECTOR_SUM_PKG_SV
package serial_vector_sum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    function automatic logic fp_is_nan(input logic [31:0] f);
        return (f[30:23] == FP_EXP_MAX) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] f);
        return f[30:0] == {FP_EXP_MAX, 23'd0};
    endfunction

endpackage
`endif

// File: rtl/FloatingAddition.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with full denormal support and a canonical quiet NaN for invalid results.
module FloatingAddition
    import serial_vector_sum_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Sum
);

    logic        swap, sub, sticky, round_up;
    logic [31:0] op_big, op_lit;
    logic [7:0]  e_big, e_lit, shift_d, shamt;
    logic [23:0] m_big, m_lit;
    logic [26:0] big_ext, lit_ext, lit_aligned, norm;
    logic [27:0] raw_sum;
    logic [4:0]  lz;
    logic [9:0]  exp_norm;
    logic [24:0] mant_rnd;
    logic [30:0] packed_mag;

    always_comb begin
        swap    = B[30:0] > A[30:0];
        op_big  = swap ? B : A;
        op_lit  = swap ? A : B;
        sub     = A[31] ^ B[31];
        // Denormals share the exponent of the smallest normal, without hidden bit.
        e_big   = (op_big[30:23] == 8'd0) ? 8'd1 : op_big[30:23];
        e_lit   = (op_lit[30:23] == 8'd0) ? 8'd1 : op_lit[30:23];
        m_big   = {|op_big[30:23], op_big[22:0]};
        m_lit   = {|op_lit[30:23], op_lit[22:0]};
        shift_d = e_big - e_lit;
        big_ext = {m_big, 3'b000};
        lit_ext = {m_lit, 3'b000};
        sticky  = 1'b0;
        if (shift_d >= 8'd27) begin
            lit_aligned = {26'd0, |m_lit};
        end else begin
            lit_aligned    = lit_ext >> shift_d;
            sticky         = |(lit_ext & ~({27{1'b1}} << shift_d));
            lit_aligned[0] = lit_aligned[0] | sticky;
        end
        raw_sum = sub ? ({1'b0, big_ext} - {1'b0, lit_aligned})
                      : ({1'b0, big_ext} + {1'b0, lit_aligned});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (raw_sum[i]) lz = 5'(26 - i);
        end
        // Left normalisation stops at the denormal boundary (exponent 1).
        shamt = ({3'b000, lz} < (e_big - 8'd1)) ? {3'b000, lz} : (e_big - 8'd1);
        if (raw_sum[27]) begin
            norm     = {raw_sum[27:2], raw_sum[1] | raw_sum[0]};
            exp_norm = {2'b00, e_big} + 10'd1;
        end else begin
            norm     = raw_sum[26:0] << shamt;
            exp_norm = {2'b00, e_big} - {2'b00, shamt};
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_rnd = {1'b0, norm[26:3]} + {24'd0, round_up};
        // Hidden bit (and any rounding carry) ripples into the exponent field.
        packed_mag = 31'({exp_norm - 10'd1, 23'd0} + {8'd0, mant_rnd});

        if (fp_is_nan(A) || fp_is_nan(B) || (fp_is_inf(A) && fp_is_inf(B) && sub)) begin
            Sum = FP_QNAN;
        end else if (fp_is_inf(A)) begin
            Sum = A;
        end else if (fp_is_inf(B)) begin
            Sum = B;
        end else if (raw_sum == 28'd0) begin
            Sum = {(sub ? 1'b0 : A[31]), 31'd0};
        end else if (exp_norm >= {2'b00, FP_EXP_MAX}) begin
            Sum = {op_big[31], FP_EXP_MAX, 23'd0};
        end else begin
            Sum = {op_big[31], packed_mag};
        end
    end

endmodule

// File: rtl/serial_vector_sum.sv
// Sums VLEN single-precision floats left to right through one time-shared adder,
// one addition per cycle, with valid/ready handshakes on both sides.
module serial_vector_sum
    import serial_vector_sum_pkg::*;
#(
    parameter int VLEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*VLEN-1:0]   Vector,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          result
);

    localparam int IDX_W = $clog2(VLEN) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

    seq_state_t         state_reg;
    logic [31:0]        acc_reg;
    logic [31:0]        acc_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [32*VLEN-1:0] vec_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [31:0]        lanes [VLEN];
    logic [31:0]        elem;

    generate
        for (genvar gi = 0; gi < VLEN; gi++) begin : g_lane
            assign lanes[gi] = vec_reg[32*gi +: 32];
        end
    endgenerate

    // Compare-based select keeps the index width independent of the lane count.
    always_comb begin
        elem = 32'd0;
        for (int i = 0; i < VLEN; i++) begin
            if (idx_reg == IDX_W'(i)) elem = lanes[i];
        end
    end

    FloatingAddition u_fadd (
        .A   (acc_reg),
        .B   (elem),
        .Sum (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= 32'd0;
            idx_reg       <= '0;
            vec_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        vec_reg      <= Vector;
                        acc_reg      <= Vector[31:0];
                        idx_reg      <= IDX_W'(1);
                        in_ready_reg <= 1'b0;
                        if (VLEN > 1) begin
                            state_reg <= ACCUM;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = acc_reg;

endmodule

// File: tb/tb_serial_vector_sum.sv
// Directed and randomized checks of serial_vector_sum at VLEN 4, 1 and 8 against
// an independent real-arithmetic reference of the left-to-right float sum.
module tb_serial_vector_sum;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         iv4 = 0, ir4, ov4, or4 = 1;
    logic [127:0] vec4 = '0;
    logic [31:0]  res4;
    logic         iv1 = 0, ir1, ov1, or1 = 1;
    logic [31:0]  vec1 = '0;
    logic [31:0]  res1;
    logic         iv8 = 0, ir8, ov8, or8 = 1;
    logic [255:0] vec8 = '0;
    logic [31:0]  res8;

    serial_vector_sum #(.VLEN(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .Vector(vec4), .out_valid(ov4), .out_ready(or4), .result(res4));
    serial_vector_sum #(.VLEN(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .Vector(vec1), .out_valid(ov1), .out_ready(or1), .result(res1));
    serial_vector_sum #(.VLEN(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .Vector(vec8), .out_valid(ov8), .out_ready(or8), .result(res8));

    int checks = 0;
    int passes = 0;
    longint cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [31:0] q4[$];
    logic [31:0] q1[$];
    logic [31:0] q8[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // ---------------- reference model (double arithmetic, rounded once to single) -------------
    function automatic real f32_to_real(input logic [31:0] f);
        real r;
        if (f[30:23] == 8'd0) begin
            r = real'(f[22:0]) * $bitstoreal({1'b0, 11'(1023 - 149), 52'd0});
            if (f[31]) r = -r;
        end else begin
            r = $bitstoreal({f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0});
        end
        return r;
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d, q, rem, half;
        logic        s;
        int          x, k;
        d = $realtobits(r);
        s = d[63];
        if (d[62:0] == 63'd0) return {s, 31'd0};
        x = int'(d[62:52]) - 1023;
        k = (x >= -126) ? 29 : 29 + (-126 - x);
        if (k > 60) return {s, 31'd0};
        q    = {11'd0, 1'b1, d[51:0]} >> k;
        rem  = {11'd0, 1'b1, d[51:0]} & ((64'd1 << k) - 64'd1);
        half = 64'd1 << (k - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (x >= -126) begin
            if (q[24]) begin
                q = q >> 1;
                x++;
            end
            if (x > 127) return {s, 8'hFF, 23'd0};
            return {s, 8'(x + 127), q[22:0]};
        end
        return {s, q[30:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic an, bn, ai, bi;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:0] == 31'h7F80_0000);
        bi = (b[30:0] == 31'h7F80_0000);
        if (an || bn || (ai && bi && a[31] != b[31])) return 32'h7FC0_0000;
        if (ai) return a;
        if (bi) return b;
        return real_to_f32(f32_to_real(a) + f32_to_real(b));
    endfunction

    function automatic logic [31:0] ref_chain(input logic [255:0] v, input int n);
        logic [31:0] acc;
        acc = v[31:0];
        for (int i = 1; i < n; i++) acc = ref_add(acc, v[32*i +: 32]);
        return acc;
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 6)       r[30:23] = 8'($urandom_range(118, 136));
        else if (sel == 6) r[30:23] = 8'h00;
        else               r[30:23] = 8'($urandom_range(0, 250));
        return r;
    endfunction

    // ---------------- handshake helpers ----------------
    task automatic send4(input logic [127:0] v, input logic [31:0] exp, input bit push,
                         output longint acc_cycle);
        iv4  = 1'b1;
        vec4 = v;
        for (int n = 0; n < 40 && !ir4; n++) @(negedge clk);
        check("send4_ready", {31'd0, ir4}, 32'd1);
        if (push) q4.push_back(exp);
        acc_cycle = cycle;
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic recv4(input string tag, input bit scramble);
        int n;
        logic [31:0] exp;
        n = 0;
        if (scramble) vec4 = {$urandom, $urandom, $urandom, $urandom};
        while (!ov4 && n < 40) begin
            @(negedge clk);
            n++;
            if (scramble) vec4 = {$urandom, $urandom, $urandom, $urandom};
        end
        check({tag, "_valid"}, {31'd0, ov4}, 32'd1);
        check({tag, "_latency"}, 32'(n), 32'd3);
        exp = (q4.size() > 0) ? q4.pop_front() : 32'hxxxx_xxxx;
        check(tag, res4, exp);
        $display("txn u4 %s result=%08h expected=%08h latency=%0d", tag, res4, exp, n);
    endtask

    task automatic xfer1(input string tag, input logic [31:0] v);
        int n;
        logic [31:0] exp;
        iv1  = 1'b1;
        vec1 = v;
        for (int w = 0; w < 40 && !ir1; w++) @(negedge clk);
        q1.push_back(v);
        @(negedge clk);
        iv1  = 1'b0;
        vec1 = ~v;
        n = 0;
        while (!ov1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd0);
        exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
        check(tag, res1, exp);
        $display("txn u1 %s result=%08h expected=%08h", tag, res1, exp);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c_a, c_b;
        logic [127:0] sp_vec[5];
        logic [31:0]  sp_exp[5];
        logic [127:0] rv;
        logic [31:0]  e8;
        bit any_valid, fired;
        int sent, got;

        sp_vec[0] = {32'h0000_0000, 32'h8000_0003, 32'h0000_0001, 32'h0000_0001}; sp_exp[0] = 32'h8000_0001;
        sp_vec[1] = {32'h0000_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF}; sp_exp[1] = 32'h7F80_0000;
        sp_vec[2] = {32'h8000_0000, 32'h8000_0000, 32'hBF80_0000, 32'h3F80_0000}; sp_exp[2] = 32'h0000_0000;
        sp_vec[3] = {32'h0000_0000, 32'h0000_0000, 32'h3380_0000, 32'h3F80_0001}; sp_exp[3] = 32'h3F80_0002;
        sp_vec[4] = {32'h0000_0000, 32'h0000_0000, 32'h3380_0000, 32'h3F80_0000}; sp_exp[4] = 32'h3F80_0000;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, ov4}, 32'd0);
        check("rst_result", res4, 32'd0);
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, ir4}, 32'd1);

        // First acceptance right after release; {4,3,2,1} sums to 10.0
        send4({32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 32'h4120_0000, 1, c_a);
        recv4("sum_10", 0);
        @(negedge clk);
        check("sum_10_one_cycle", {31'd0, ov4}, 32'd0);
        check("sum_10_idle_ready", {31'd0, ir4}, 32'd1);

        // Consumer stalls 5 cycles while new requests are presented
        or4 = 1'b0;
        send4({32'hBE80_0000, 32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000}, 32'h4050_0000, 1, c_a);
        recv4("stall", 0);
        for (int i = 0; i < 5; i++) begin
            iv4  = 1'b1;
            vec4 = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("stall_hold_valid", {31'd0, ov4}, 32'd1);
            check("stall_hold_result", res4, 32'h4050_0000);
            check("stall_busy_ready", {31'd0, ir4}, 32'd0);
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        @(negedge clk);
        check("stall_release_valid", {31'd0, ov4}, 32'd0);
        check("stall_release_ready", {31'd0, ir4}, 32'd1);

        // Operand bus scrambled every cycle after acceptance
        send4({32'h4180_0000, 32'h4100_0000, 32'h3E80_0000, 32'h3F00_0000}, 32'h41C6_0000, 1, c_a);
        recv4("scramble", 1);
        @(negedge clk);

        // Reset in the middle of an accumulation
        send4({32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 32'h0, 0, c_a);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, ov4}, 32'd0);
        check("midrst_result", res4, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_valid = any_valid | ov4;
        end
        check("midrst_no_valid", {31'd0, any_valid}, 32'd0);
        send4({4{32'h3F80_0000}}, 32'h4080_0000, 1, c_a);
        recv4("after_rst", 0);
        @(negedge clk);

        // Special values and rounding corners
        for (int i = 0; i < 5; i++) begin
            send4(sp_vec[i], sp_exp[i], 1, c_a);
            recv4($sformatf("special%0d", i), 0);
            @(negedge clk);
        end

        // Back-to-back: second request waits and goes in on the first IDLE cycle
        rv = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
        send4(rv, ref_chain({128'd0, rv}, 4), 1, c_a);
        recv4("b2b_first", 0);
        rv = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
        send4(rv, ref_chain({128'd0, rv}, 4), 1, c_b);
        check("b2b_interval", 32'(c_b - c_a), 32'd5);
        recv4("b2b_second", 0);

        // Single-element vectors pass through unmodified
        xfer1("v1_pi", 32'hC049_0FDB);
        xfer1("v1_snan", 32'h7FA0_0001);
        xfer1("v1_denorm", 32'h8000_0005);

        // Randomized VLEN=8 stream with random consumer back-pressure
        sent  = 0;
        got   = 0;
        fired = 1'b0;
        for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
            @(negedge clk);
            if (fired) begin
                for (int i = 0; i < 8; i++) vec8[32*i +: 32] = rand_elem();
                iv8   = (sent < 1000) && ($urandom_range(0, 3) != 0);
                fired = 1'b0;
            end else if (!iv8 && sent < 1000 && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) vec8[32*i +: 32] = rand_elem();
                iv8 = 1'b1;
            end
            or8 = 1'($urandom_range(0, 1));
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    check("rnd_duplicate", {31'd0, ov8}, 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    check($sformatf("rnd%0d", got), res8, e8);
                    $display("txn u8 rnd%0d result=%08h expected=%08h", got, res8, e8);
                end
                got++;
            end
            if (iv8 && ir8) begin
                q8.push_back(ref_chain(vec8, 8));
                sent++;
                fired = 1'b1;
            end
        end
        iv8 = 1'b0;
        check("rnd_count", 32'(got), 32'd1000);
        check("rnd_queue_empty", 32'(q8.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
